// File: rtl/rv32m_muldiv_seq_if.sv
// rv32m_muldiv_seq_if: request/response bundle between EX-stage control and the muldiv sequencer
interface rv32m_muldiv_seq_if #(parameter int XLEN = 32);
  logic start, flush, busy, done;
  logic [2:0] func3;
  logic [XLEN-1:0] op_a, op_b, result;
  modport master (output start, flush, func3, op_a, op_b, input busy, done, result);
  modport slave (input start, flush, func3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/rv32m_muldiv_seq.sv
// rv32m_muldiv_seq: 32-step RV32M multiply/divide sequencer; MULDIV_EARLY_OUT_EN lets trivial operands skip CALC
module rv32m_muldiv_seq #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  rv32m_muldiv_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, ua_q, ua_d, ub_q, ub_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [4:0] cnt_q, cnt_d;
  logic neg_q, neg_d, negr_q, negr_d, div0_q, div0_d, ovf_q, ovf_d;
  logic sa, sb, na, nb, dz, ov, skip, ge;
  logic [XLEN:0] sum, sh;
  logic [XLEN-1:0] diff, quo, rem, sel;
  always_comb begin
    sa = f3_q == 3'b001 || f3_q == 3'b010 || (f3_q[2] && !f3_q[0]);
    sb = f3_q == 3'b001 || (f3_q[2] && !f3_q[0]);
    na = sa && a_q[XLEN-1];
    nb = sb && b_q[XLEN-1];
    dz = f3_q[2] && b_q == '0;
    ov = f3_q[2] && !f3_q[0] && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1;
`ifdef MULDIV_EARLY_OUT_EN
    skip = dz || ov || (!f3_q[2] && (a_q == '0 || b_q == '0));
`else
    skip = 1'b0;
`endif
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, ua_q};
    sh = {acc_q[2*XLEN-1:XLEN], ua_q[~cnt_q]};
    ge = sh >= {1'b0, ub_q};
    diff = sh[XLEN-1:0] - ub_q;
    prod = neg_q ? -acc_q : acc_q;
    quo = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    sel = div0_q ? (f3_q[1] ? a_q : {XLEN{1'b1}}) :
          ovf_q ? (f3_q[1] ? '0 : a_q) :
          f3_q[2] ? (f3_q[1] ? rem : quo) :
          f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    state_d = state_q;
    f3_d = f3_q;
    a_d = a_q;
    b_d = b_q;
    ua_d = ua_q;
    ub_d = ub_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    negr_d = negr_q;
    div0_d = div0_q;
    ovf_d = ovf_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = PREP;
        f3_d = bus.func3;
        a_d = bus.op_a;
        b_d = bus.op_b;
      end
      PREP: begin
        ua_d = na ? -a_q : a_q;
        ub_d = nb ? -b_q : b_q;
        neg_d = na ^ nb;
        negr_d = na;
        div0_d = dz;
        ovf_d = ov;
        acc_d = '0;
        cnt_d = '0;
        state_d = skip ? FIX : CALC;
      end
      CALC: begin
        acc_d = f3_q[2] ? {ge ? diff : sh[XLEN-1:0], acc_q[XLEN-2:0], ge} :
                ub_q[cnt_q] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        cnt_d = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? FIX : CALC;
      end
      FIX: begin
        result_d = sel;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      result_d = result_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ua_q <= '0;
      ub_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
      ovf_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      f3_q <= f3_d;
      a_q <= a_d;
      b_q <= b_d;
      ua_q <= ua_d;
      ub_q <= ub_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      negr_q <= negr_d;
      div0_q <= div0_d;
      ovf_q <= ovf_d;
      result_q <= result_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.result = result_q;
endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// tb_rv32m_muldiv_seq: directed and randomized check of rv32m_muldiv_seq against a behavioural model
module tb_rv32m_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit m_act = 1'b0;
  int m_k = 0;
  int m_lat = 35;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;
  rv32m_muldiv_seq_if #(.XLEN(32)) io ();
  rv32m_muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(io));
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xs, xu, ys, yu, p;
    xs = {{32{a[31]}}, a};
    xu = {32'b0, a};
    ys = {{32{b[31]}}, b};
    yu = {32'b0, b};
    case (f)
      3'd0: p = xs * ys;
      3'd1: p = (xs * ys) >>> 32;
      3'd2: p = (xs * yu) >>> 32;
      3'd3: p = (xu * yu) >> 32;
      3'd4: p = b == 0 ? -64'sd1 : xs / ys;
      3'd5: p = b == 0 ? -64'sd1 : xu / yu;
      3'd6: p = b == 0 ? xs : xs % ys;
      default: p = b == 0 ? xu : xu % yu;
    endcase
    return p[31:0];
  endfunction
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic early;
    early = f[2] ? (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) : (a == 0 || b == 0);
`ifdef MULDIV_EARLY_OUT_EN
    return early ? 3 : 35;
`else
    return early ? 35 : 35;
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0;
      m_res <= '0;
    end else if (io.flush) m_act <= 1'b0;
    else if (!m_act) begin
      if (io.start) begin
        m_act <= 1'b1;
        m_k <= 1;
        m_pend <= ref_res(io.func3, io.op_a, io.op_b);
        m_lat <= lat_of(io.func3, io.op_a, io.op_b);
      end
    end else if (m_k == m_lat) m_act <= 1'b0;
    else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat) m_res <= m_pend;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("busy", {31'b0, io.busy}, {31'b0, m_act});
    chk("done", {31'b0, io.done}, {31'b0, m_act && m_k == m_lat});
    chk("result", io.result, m_res);
  end
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input string nm);
    int cyc;
    io.start = 1'b1;
    io.func3 = f;
    io.op_a = a;
    io.op_b = b;
    @(negedge clk);
    io.start = 1'b0;
    io.func3 = 3'($urandom);
    io.op_a = $urandom;
    io.op_b = $urandom;
    cyc = 1;
    while (!io.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, cyc, lat_of(f, a, b));
    chk({nm, " result"}, io.result, r);
    @(negedge clk);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int cyc, ndone, k;
    logic [2:0] f;
    logic [31:0] a, b, held;
    io.start = 1'b0;
    io.flush = 1'b0;
    io.func3 = '0;
    io.op_a = '0;
    io.op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, io.busy}, 32'd0);
    chk("reset done", {31'b0, io.done}, 32'd0);
    chk("reset result", io.result, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    run_op(3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, "mul");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    run_op(3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, "div");
    run_op(3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, "rem");
    run_op(3'd5, 32'h7, 32'h2, 32'h3, "divu");
    run_op(3'd7, 32'h7, 32'h2, 32'h1, "remu");
    run_op(3'd4, 32'h5, 32'h0, 32'hFFFFFFFF, "div by zero");
    run_op(3'd6, 32'h5, 32'h0, 32'h5, "rem by zero");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div overflow");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem overflow");
    run_op(3'd0, 32'h0, 32'h1234, 32'h0, "mul zero");
    io.start = 1'b1;
    io.func3 = 3'd0;
    io.op_a = 32'd3;
    io.op_b = 32'd5;
    @(negedge clk);
    io.start = 1'b0;
    cyc = 1;
    ndone = 0;
    held = '0;
    while (cyc <= 36) begin
      io.start = cyc >= 5 && cyc <= 20;
      io.op_a = $urandom;
      io.op_b = $urandom;
      io.func3 = 3'($urandom);
      if (io.done) begin
        ndone++;
        held = io.result;
      end
      @(negedge clk);
      cyc++;
    end
    io.start = 1'b0;
    chk("busy start done count", ndone, 32'd1);
    chk("busy start result", held, 32'd15);
    io.start = 1'b1;
    io.func3 = 3'd5;
    io.op_a = 32'd100;
    io.op_b = 32'd7;
    @(negedge clk);
    io.start = 1'b0;
    repeat (9) @(negedge clk);
    io.flush = 1'b1;
    @(negedge clk);
    io.flush = 1'b0;
    chk("flush busy", {31'b0, io.busy}, 32'd0);
    chk("flush result kept", io.result, 32'd15);
    @(negedge clk);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "after flush");
    io.start = 1'b1;
    io.func3 = 3'd1;
    io.op_a = 32'h12345678;
    io.op_b = 32'h9ABCDEF0;
    @(negedge clk);
    io.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset busy", {31'b0, io.busy}, 32'd0);
    chk("mid reset done", {31'b0, io.done}, 32'd0);
    chk("mid reset result", io.result, 32'd0);
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(f, a, b, ref_res(f, a, b), "random");
    end
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(1, 34);
      io.start = 1'b1;
      io.func3 = 3'($urandom_range(0, 7));
      io.op_a = pick();
      io.op_b = pick();
      @(negedge clk);
      io.start = 1'b0;
      repeat (k - 1) @(negedge clk);
      io.flush = 1'b1;
      @(negedge clk);
      io.flush = 1'b0;
      chk("random flush busy", {31'b0, io.busy}, 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
